ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Sequences the single shared system RAM (sync read, 1-cycle latency) among three requesters: the UART program loader, the VGA screen reader and the 6502 CPU.
- Replaces ad-hoc ready/pre-ready logic in the top level with a proper state machine.
- Stalls the CPU via RDY only at instruction boundaries (SYNC).
- Restores the CPU address on the RAM one cycle before releasing RDY.
- Holds the CPU in reset during and after program loading.

Parameters:
ADDR_WIDTH, 11, RAM address width
DATA_WIDTH, 8, RAM data width
CPU_MIN_RUN, 8, minimum cycles the CPU owns RAM between video grants (anti-starvation)
MAX_VID_HOLD, 64, maximum consecutive cycles of one video grant
RESET_CYCLES, 4, cycles cpu_hold_reset stays high after the loader releases

Ports:
clk  in  1  system clock (25 MHz)
reset_n  in  1  asynchronous active-low reset
cpu_addr  in  16  CPU address bus; low ADDR_WIDTH bits used
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_we  in  1  CPU write enable
cpu_sync  in  1  CPU is fetching an opcode
cpu_rdy  out  1  CPU RDY
cpu_hold_reset  out  1  CPU reset request
vid_req  in  1  video wants RAM (level)
vid_addr  in  ADDR_WIDTH  video read address
vid_gnt  out  1  video owns RAM this cycle
vid_rvalid  out  1  ram_rdata holds data for vid_addr of previous cycle
ldr_req  in  1  loader wants RAM (level, held for whole load)
ldr_addr  in  ADDR_WIDTH  loader write address
ldr_wdata  in  DATA_WIDTH  loader write data
ldr_we  in  1  loader write strobe
ldr_gnt  out  1  loader owns RAM
ram_addr  out  ADDR_WIDTH  to RAM waddr and raddr
ram_wdata  out  DATA_WIDTH  to RAM din
ram_we  out  1  to RAM write_en

Behaviour:
- State register is async-cleared by reset_n low. Reset state is CPU_RST with cnt=0.
- Reset output values: cpu_rdy=0, cpu_hold_reset=1, vid_gnt=0, ldr_gnt=0, vid_rvalid=0, ram_we=0.
- States: CPU_RST, CPU_RUN, GRANT_VID, GRANT_LDR, RESTORE.
- All outputs are decoded from the registered state. The ram_* mux is combinational on state.
- Priority: loader > video > CPU. ldr_req is checked in every state.
- CPU_RST:
  - mux=cpu, cpu_hold_reset=1, cpu_rdy=0.
  - Stay while cnt < RESET_CYCLES-1, counting each cycle, then go to CPU_RUN.
  - ldr_req=1 goes to GRANT_LDR.
- CPU_RUN:
  - mux=cpu, cpu_rdy=1, ram_we=cpu_we.
  - run_cnt clears on entry and saturates at CPU_MIN_RUN.
  - ldr_req=1 goes to GRANT_LDR next cycle with no SYNC wait, because the CPU is reset anyway.
  - vid_req=1 and cpu_sync=1 and run_cnt==CPU_MIN_RUN goes to GRANT_VID.
- GRANT_VID:
  - mux=vid, ram_we=0, vid_gnt=1, cpu_rdy=0.
  - hold_cnt clears on entry.
  - vid_req=0, or hold_cnt==MAX_VID_HOLD-1, goes to RESTORE.
- RESTORE:
  - mux=cpu, ram_we=0, cpu_rdy=0. Lasts exactly 1 cycle so RAM output reflects cpu_addr.
  - Then CPU_RUN, or GRANT_LDR if ldr_req=1.
- GRANT_LDR:
  - mux=ldr, ram_we=ldr_we, ldr_gnt=1, cpu_hold_reset=1, cpu_rdy=0.
  - ldr_req=0 goes to CPU_RST with cnt=0.
- vid_rvalid = registered (state==GRANT_VID). It lags vid_gnt by exactly 1 cycle and clears 1 cycle after exit.
- ram_we is never 1 outside CPU_RUN and GRANT_LDR.
- A CPU write is never issued while cpu_rdy=0.
- Simultaneous vid_req and ldr_req in CPU_RUN: loader wins. The video retries after the load completes.
- ldr_req rising during GRANT_VID: next state is GRANT_LDR. vid_gnt drops that cycle; video data is discarded.
- reset_n low mid-grant: outputs take reset values immediately (async); no write occurs.
- Address truncation: cpu_addr[ADDR_WIDTH-1:0]. There is no decode of higher bits.

Decomposition:
- Shared package holds the state encoding constants (ARB_CPU_RST, ARB_CPU_RUN, ARB_GRANT_VID, ARB_GRANT_LDR, ARB_RESTORE).
- Default widths also live in the package.
- Single module; no sub-module is needed. The counters (cnt/run_cnt/hold_cnt) share one register reused per state.

Test Plan:
- Reset release, no requests -> cpu_hold_reset=1 for 4 cycles, then cpu_rdy=1; ram_addr follows cpu_addr.
- vid_req=1 with cpu_sync pulse after ≥8 CPU_RUN cycles -> next cycle vid_gnt=1, cpu_rdy=0, ram_addr=vid_addr, vid_rvalid high 1 cycle later.
- vid_req held 100 cycles -> vid_gnt high exactly 64 cycles, then 1 RESTORE cycle (ram_addr=cpu_addr, cpu_rdy=0), then cpu_rdy=1 for ≥8 cycles before the next grant.
- vid_req=1 but cpu_sync=0 -> no grant until sync; cpu_we=1 with addr 0x0200 writes RAM only while cpu_rdy=1.
- ldr_req during GRANT_VID, loader writes 0x5A to 0x600 -> vid_gnt drops, ldr_gnt=1, ram_we=1 with addr 0x600; after ldr_req falls, cpu_hold_reset=1 for 4 cycles, then CPU_RUN.
- reset_n low mid-load -> ldr_gnt=0, ram_we=0 asynchronously, cpu_hold_reset=1.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the system RAM arbiter: state encoding, default widths
// and timing constants, and a helper used to size the shared counter.
package ram_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH   = 11;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_CPU_MIN_RUN  = 8;
  localparam int DEF_MAX_VID_HOLD = 64;
  localparam int DEF_RESET_CYCLES = 4;
  localparam int CPU_ADDR_WIDTH   = 16;

  typedef enum logic [2:0] {
    ARB_CPU_RST   = 3'd0,
    ARB_CPU_RUN   = 3'd1,
    ARB_GRANT_VID = 3'd2,
    ARB_GRANT_LDR = 3'd3,
    ARB_RESTORE   = 3'd4
  } arb_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of requester, RAM and debug signals around the RAM arbiter.
// slave = arbiter side, master = requesters/RAM side.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    // Requests are levels: a requester keeps req high as long as it wants RAM,
    // and owns the RAM in exactly the cycles its gnt is high. vid_rvalid marks
    // ram_rdata as belonging to the vid_addr presented one cycle earlier.
    logic [CPU_ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0]     cpu_wdata;
    logic                      cpu_we;
    logic                      cpu_sync;
    logic                      cpu_rdy;
    logic                      cpu_hold_reset;

    logic                      vid_req;
    logic [ADDR_WIDTH-1:0]     vid_addr;
    logic                      vid_gnt;
    logic                      vid_rvalid;

    logic                      ldr_req;
    logic [ADDR_WIDTH-1:0]     ldr_addr;
    logic [DATA_WIDTH-1:0]     ldr_wdata;
    logic                      ldr_we;
    logic                      ldr_gnt;

    logic [ADDR_WIDTH-1:0]     ram_addr;
    logic [DATA_WIDTH-1:0]     ram_wdata;
    logic                      ram_we;

    arb_state_e                dbg_state;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_sync,
        output cpu_rdy, cpu_hold_reset,
        input  vid_req, vid_addr,
        output vid_gnt, vid_rvalid,
        input  ldr_req, ldr_addr, ldr_wdata, ldr_we,
        output ldr_gnt,
        output ram_addr, ram_wdata, ram_we,
        output dbg_state
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, cpu_sync,
        input  cpu_rdy, cpu_hold_reset,
        output vid_req, vid_addr,
        input  vid_gnt, vid_rvalid,
        output ldr_req, ldr_addr, ldr_wdata, ldr_we,
        input  ldr_gnt,
        input  ram_addr, ram_wdata, ram_we,
        input  dbg_state
    );

endinterface

// File: rtl/ram_arbiter.sv
// Shares the single sync-read system RAM between the program loader, the video
// reader and the 6502; the CPU is only stalled at opcode fetch boundaries.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int CPU_MIN_RUN  = DEF_CPU_MIN_RUN,
    parameter int MAX_VID_HOLD = DEF_MAX_VID_HOLD,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic          clk,
    input  logic          reset_n,
    ram_arbiter_if.slave  bus
);

    localparam int CNT_MAX = max3(RESET_CYCLES, CPU_MIN_RUN, MAX_VID_HOLD);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_MIN   = CNT_W'(CPU_MIN_RUN);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_VID_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vid_rvalid_q;

    // Upper CPU address bits are intentionally ignored: no decode above the RAM.
    logic unused_cpu_addr_hi;
    assign unused_cpu_addr_hi = ^bus.cpu_addr[CPU_ADDR_WIDTH-1:ADDR_WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB_CPU_RST;
            cnt_q        <= '0;
            vid_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vid_rvalid_q <= (state_q == ARB_GRANT_VID);
        end
    end

    // One counter serves as reset timer, CPU run length and video hold length.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_CPU_RST: begin
                if (bus.ldr_req) begin
                    state_d = ARB_GRANT_LDR;
                    cnt_d   = '0;
                end else if (cnt_q < RST_LAST) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    state_d = ARB_CPU_RUN;
                    cnt_d   = '0;
                end
            end
            ARB_CPU_RUN: begin
                if (bus.ldr_req) begin
                    state_d = ARB_GRANT_LDR;
                    cnt_d   = '0;
                end else if (bus.vid_req && bus.cpu_sync && (cnt_q == RUN_MIN)) begin
                    state_d = ARB_GRANT_VID;
                    cnt_d   = '0;
                end else if (cnt_q != RUN_MIN) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ARB_GRANT_VID: begin
                if (bus.ldr_req) begin
                    state_d = ARB_GRANT_LDR;
                    cnt_d   = '0;
                end else if (!bus.vid_req || (cnt_q == HOLD_LAST)) begin
                    state_d = ARB_RESTORE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ARB_RESTORE: begin
                state_d = bus.ldr_req ? ARB_GRANT_LDR : ARB_CPU_RUN;
                cnt_d   = '0;
            end
            ARB_GRANT_LDR: begin
                if (!bus.ldr_req) begin
                    state_d = ARB_CPU_RST;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ARB_CPU_RST;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bus.cpu_rdy        = 1'b0;
        bus.cpu_hold_reset = 1'b0;
        bus.vid_gnt        = 1'b0;
        bus.ldr_gnt        = 1'b0;
        bus.ram_addr       = bus.cpu_addr[ADDR_WIDTH-1:0];
        bus.ram_wdata      = bus.cpu_wdata;
        bus.ram_we         = 1'b0;
        case (state_q)
            ARB_CPU_RST: begin
                bus.cpu_hold_reset = 1'b1;
            end
            ARB_CPU_RUN: begin
                bus.cpu_rdy = 1'b1;
                bus.ram_we  = bus.cpu_we;
            end
            ARB_GRANT_VID: begin
                bus.vid_gnt  = 1'b1;
                bus.ram_addr = bus.vid_addr;
            end
            ARB_GRANT_LDR: begin
                bus.ldr_gnt        = 1'b1;
                bus.cpu_hold_reset = 1'b1;
                bus.ram_addr       = bus.ldr_addr;
                bus.ram_wdata      = bus.ldr_wdata;
                bus.ram_we         = bus.ldr_we;
            end
            // RESTORE keeps the CPU address on the RAM so read data is valid at RDY.
            default: begin
            end
        endcase
    end

    assign bus.vid_rvalid = vid_rvalid_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset timing, video grant/hold/restore,
// loader preemption and asynchronous reset during a load.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  int   n;

  ram_arbiter_if #(.ADDR_WIDTH(11), .DATA_WIDTH(8)) bus ();

  ram_arbiter #(
    .ADDR_WIDTH(11), .DATA_WIDTH(8), .CPU_MIN_RUN(8),
    .MAX_VID_HOLD(64), .RESET_CYCLES(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b1;
    bus.cpu_addr  = 16'hFD23;
    bus.cpu_wdata = 8'h00;
    bus.cpu_we    = 1'b0;
    bus.cpu_sync  = 1'b0;
    bus.vid_req   = 1'b0;
    bus.vid_addr  = 11'h0AB;
    bus.ldr_req   = 1'b0;
    bus.ldr_addr  = 11'h000;
    bus.ldr_wdata = 8'h00;
    bus.ldr_we    = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_rdy",    32'(bus.cpu_rdy), 32'd0);
    chk("rst_hold",   32'(bus.cpu_hold_reset), 32'd1);
    chk("rst_vgnt",   32'(bus.vid_gnt), 32'd0);
    chk("rst_lgnt",   32'(bus.ldr_gnt), 32'd0);
    chk("rst_rvalid", 32'(bus.vid_rvalid), 32'd0);
    chk("rst_we",     32'(bus.ram_we), 32'd0);
    chk("rst_state",  32'(bus.dbg_state), 32'(ARB_CPU_RST));
    tick();
    tick();
    reset_n = 1'b1;

    // Four cycles of held reset, then the CPU runs.
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("boot_hold", 32'(bus.cpu_hold_reset), 32'd1);
      chk("boot_rdy",  32'(bus.cpu_rdy), 32'd0);
      tick();
    end
    #1;
    chk("run_state", 32'(bus.dbg_state), 32'(ARB_CPU_RUN));
    chk("run_rdy",   32'(bus.cpu_rdy), 32'd1);
    chk("run_hold",  32'(bus.cpu_hold_reset), 32'd0);
    chk("run_trunc", 32'(bus.ram_addr), 32'h523);

    bus.cpu_addr  = 16'h0200;
    bus.cpu_wdata = 8'h77;
    bus.cpu_we    = 1'b1;
    #1;
    chk("cpu_we",    32'(bus.ram_we), 32'd1);
    chk("cpu_waddr", 32'(bus.ram_addr), 32'h200);
    chk("cpu_wdata", 32'(bus.ram_wdata), 32'h77);
    bus.cpu_we = 1'b0;

    // Video waits while the CPU is mid-instruction.
    bus.vid_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      chk("nosync_vgnt", 32'(bus.vid_gnt), 32'd0);
      chk("nosync_rdy",  32'(bus.cpu_rdy), 32'd1);
    end
    bus.cpu_sync = 1'b1;
    #1;
    chk("sync_rdy", 32'(bus.cpu_rdy), 32'd1);
    tick();
    bus.cpu_sync = 1'b0;
    bus.cpu_we   = 1'b1;
    #1;
    chk("vid_gnt",    32'(bus.vid_gnt), 32'd1);
    chk("vid_rdy",    32'(bus.cpu_rdy), 32'd0);
    chk("vid_addr",   32'(bus.ram_addr), 32'h0AB);
    chk("vid_rv0",    32'(bus.vid_rvalid), 32'd0);
    chk("vid_nowe",   32'(bus.ram_we), 32'd0);
    bus.cpu_we = 1'b0;

    // Held request: grant capped, then one restore cycle.
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.vid_gnt !== 1'b1) break;
      n++;
      if (i == 1) chk("vid_rv1", 32'(bus.vid_rvalid), 32'd1);
      tick();
    end
    chk("vid_hold_len", 32'(n), 32'd64);
    bus.cpu_we = 1'b1;
    #1;
    chk("rest_state", 32'(bus.dbg_state), 32'(ARB_RESTORE));
    chk("rest_rdy",   32'(bus.cpu_rdy), 32'd0);
    chk("rest_addr",  32'(bus.ram_addr), 32'h200);
    chk("rest_we",    32'(bus.ram_we), 32'd0);
    chk("rest_rv",    32'(bus.vid_rvalid), 32'd1);
    bus.cpu_we = 1'b0;
    tick();
    chk("run2_rv", 32'(bus.vid_rvalid), 32'd0);

    bus.cpu_sync = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.vid_gnt === 1'b1) break;
      if (bus.cpu_rdy === 1'b1) n++;
      tick();
    end
    chk("cpu_min_run", 32'(n), 32'd9);
    chk("vid_gnt2",    32'(bus.vid_gnt), 32'd1);
    bus.cpu_sync = 1'b0;

    // Loader preempts the video grant.
    bus.ldr_req   = 1'b1;
    bus.ldr_addr  = 11'h600;
    bus.ldr_wdata = 8'h5A;
    bus.ldr_we    = 1'b1;
    #1;
    chk("pre_lgnt", 32'(bus.ldr_gnt), 32'd0);
    tick();
    chk("ldr_vgnt",  32'(bus.vid_gnt), 32'd0);
    chk("ldr_gnt",   32'(bus.ldr_gnt), 32'd1);
    chk("ldr_we",    32'(bus.ram_we), 32'd1);
    chk("ldr_addr",  32'(bus.ram_addr), 32'h600);
    chk("ldr_wdata", 32'(bus.ram_wdata), 32'h5A);
    chk("ldr_hold",  32'(bus.cpu_hold_reset), 32'd1);
    chk("ldr_rdy",   32'(bus.cpu_rdy), 32'd0);
    bus.ldr_we  = 1'b0;
    bus.vid_req = 1'b0;
    #1;
    chk("ldr_we_off", 32'(bus.ram_we), 32'd0);
    tick();
    bus.ldr_req = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("post_ldr_hold", 32'(bus.cpu_hold_reset), 32'd1);
      chk("post_ldr_lgnt", 32'(bus.ldr_gnt), 32'd0);
      tick();
    end
    chk("post_ldr_run", 32'(bus.dbg_state), 32'(ARB_CPU_RUN));

    // Simultaneous video and loader requests once the CPU may yield.
    for (int i = 0; i < 9; i++) tick();
    bus.vid_req  = 1'b1;
    bus.cpu_sync = 1'b1;
    bus.ldr_req  = 1'b1;
    bus.ldr_we   = 1'b1;
    tick();
    chk("both_lgnt", 32'(bus.ldr_gnt), 32'd1);
    chk("both_vgnt", 32'(bus.vid_gnt), 32'd0);
    chk("both_we",   32'(bus.ram_we), 32'd1);

    // Asynchronous reset in the middle of a load.
    reset_n = 1'b0;
    #1;
    chk("arst_lgnt", 32'(bus.ldr_gnt), 32'd0);
    chk("arst_we",   32'(bus.ram_we), 32'd0);
    chk("arst_hold", 32'(bus.cpu_hold_reset), 32'd1);
    chk("arst_rdy",  32'(bus.cpu_rdy), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
